// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one memory port between NUM_REQ
//               requesters. At most one access is accepted per cycle. Memory
//               strobes, address and write data are registered. Read returns
//               are steered back to the requester that issued the read.
//               Locked sequences pin the grant to one owner for up to
//               MAX_LOCK beats, so bursts are not interleaved.
// Ports       : hclk, hresetn        - clock, asynchronous active-low reset
//               req/req_wr/req_lock  - per-requester request, write, lock
//               req_addr/req_wdata   - flattened per-requester address/data
//               gnt                  - combinational one-hot grant
//               rd_valid/rd_data     - one-hot read return strobe and data
//               mem_*                - registered memory-side port
//               lock_active          - high while in the locked state
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_LOCK   = 16
) (
    input  logic                          hclk,
    input  logic                          hresetn,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          mem_rd_en,
    output logic                          mem_wr_en,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wr_data,
    input  logic [DATA_WIDTH-1:0]         mem_rd_data,
    output logic                          lock_active
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] c_LOCK_LAST = CNT_W'(MAX_LOCK - 1);

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [IDX_W-1:0]        r_rr_ptr, w_rr_ptr_nxt;
    logic [IDX_W-1:0]        r_owner, w_owner_nxt;
    logic [CNT_W-1:0]        r_lock_cnt, w_lock_cnt_nxt;
    logic [IDX_W-1:0]        r_rd_owner;

    logic [NUM_REQ-1:0]      w_gnt_raw;
    logic [NUM_REQ-1:0]      w_gnt;
    logic                    w_accept;
    logic [IDX_W-1:0]        w_gnt_idx;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;
    logic                    w_sel_wr;
    logic                    w_sel_lock;
    int                      w_cand;
    logic                    w_found;

    // Read-tracking shift pipeline: stage s holds the read issued s+1 cycles ago
    logic                    r_pipe_vld [RD_LATENCY];
    logic [IDX_W-1:0]        r_pipe_id  [RD_LATENCY];

    function automatic logic [IDX_W-1:0] f_next_idx(input logic [IDX_W-1:0] idx);
        if (int'(idx) == NUM_REQ - 1) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

    // Grant: pinned to the owner while locked, else first requester at or
    // after the round-robin pointer (with wrap-around).
    always_comb begin
        w_gnt_raw = '0;
        w_found   = 1'b0;
        w_cand    = 0;
        if (r_state == ST_LOCKED) begin
            w_gnt_raw[r_owner] = req[r_owner];
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_cand = int'(r_rr_ptr) + k;
                if (w_cand >= NUM_REQ) begin
                    w_cand = w_cand - NUM_REQ;
                end
                if (!w_found && req[w_cand[IDX_W-1:0]]) begin
                    w_gnt_raw[w_cand[IDX_W-1:0]] = 1'b1;
                    w_found                      = 1'b1;
                end
            end
        end
    end

    // Nothing may be granted while reset is asserted.
    assign w_gnt    = w_gnt_raw & {NUM_REQ{hresetn}};
    assign gnt      = w_gnt;
    assign w_accept = |w_gnt;

    // One-hot grant to index plus selection of the granted requester's fields
    always_comb begin
        w_gnt_idx   = '0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wr    = 1'b0;
        w_sel_lock  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt[k]) begin
                w_gnt_idx   = IDX_W'(k);
                w_sel_addr  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
                w_sel_wr    = req_wr[k];
                w_sel_lock  = req_lock[k];
            end
        end
    end

    // Arbitration state: pointer, lock owner and beat counter
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_lock_cnt_nxt = r_lock_cnt;
        w_rr_ptr_nxt   = r_rr_ptr;
        if (w_accept) begin
            w_rr_ptr_nxt = f_next_idx(w_gnt_idx);
        end
        case (r_state)
            ST_ARB: begin
                // A single-beat cap means the lock ends on the beat that opens it
                if (w_accept && w_sel_lock && (MAX_LOCK > 1)) begin
                    w_state_nxt    = ST_LOCKED;
                    w_owner_nxt    = w_gnt_idx;
                    w_lock_cnt_nxt = CNT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (!w_accept) begin
                    // Owner dropped its request
                    w_state_nxt    = ST_ARB;
                    w_lock_cnt_nxt = '0;
                    w_rr_ptr_nxt   = f_next_idx(r_owner);
                end else if (!w_sel_lock || (r_lock_cnt == c_LOCK_LAST)) begin
                    w_state_nxt    = ST_ARB;
                    w_lock_cnt_nxt = '0;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt    = ST_ARB;
                w_lock_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state    <= ST_ARB;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    // Registered memory port; address/data hold when nothing is accepted
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            r_rd_owner  <= '0;
        end else if (w_accept) begin
            mem_rd_en   <= !w_sel_wr;
            mem_wr_en   <= w_sel_wr;
            mem_addr    <= w_sel_addr;
            mem_wr_data <= w_sel_wdata;
            r_rd_owner  <= w_gnt_idx;
        end else begin
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                r_pipe_vld[s] <= 1'b0;
                r_pipe_id[s]  <= '0;
            end
        end else begin
            r_pipe_vld[0] <= mem_rd_en;
            r_pipe_id[0]  <= r_rd_owner;
            for (int s = 1; s < RD_LATENCY; s++) begin
                r_pipe_vld[s] <= r_pipe_vld[s-1];
                r_pipe_id[s]  <= r_pipe_id[s-1];
            end
        end
    end

    always_comb begin
        rd_valid = '0;
        if (r_pipe_vld[RD_LATENCY-1]) begin
            rd_valid[r_pipe_id[RD_LATENCY-1]] = 1'b1;
        end
    end

    assign rd_data     = mem_rd_data;
    assign lock_active = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter with a memory
//               responder, a rule-level reference model and directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int RDL = 2;
    localparam int ML  = 4;

    logic            hclk    = 1'b0;
    logic            hresetn = 1'b0;
    logic [N-1:0]    req;
    logic [N-1:0]    req_wr;
    logic [N-1:0]    req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rd_valid;
    logic [DW-1:0]   rd_data;
    logic            mem_rd_en;
    logic            mem_wr_en;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wr_data;
    logic [DW-1:0]   mem_rd_data;
    logic            lock_active;

    mem_port_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_LATENCY (RDL),
        .MAX_LOCK   (ML)
    ) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .req         (req),
        .req_wr      (req_wr),
        .req_lock    (req_lock),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .lock_active (lock_active)
    );

    always #5 hclk = ~hclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory responder: data appears RDL cycles after the mem_rd_en cycle
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] rpipe [RDL];

    always @(posedge hclk) begin
        for (int s = RDL - 1; s > 0; s--) rpipe[s] <= rpipe[s-1];
        rpipe[0] <= (mem_rd_en && mem.exists(mem_addr)) ? mem[mem_addr] : dflt(mem_addr);
        if (mem_wr_en) mem[mem_addr] = mem_wr_data;
    end
    assign mem_rd_data = rpipe[RDL-1];

    // Reference model: rule-level state and a schedule of expected returns
    int            cyc = 0;
    int            m_ptr = 0, m_owner = 0, m_cnt = 0;
    bit            m_locked = 0;
    logic          m_rd = 0, m_wr = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    int            ret_owner [int];
    logic [DW-1:0] ret_data  [int];

    always @(negedge hclk) begin : compare
        logic [N-1:0] exp_gnt;
        logic [N-1:0] exp_rv;
        int           g;
        cyc++;
        if (!hresetn) begin
            m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0;
            m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
            ret_owner.delete();
            ret_data.delete();
            chk("rst_gnt", gnt, 0);
            chk("rst_rd_valid", rd_valid, 0);
            chk("rst_mem_rd_en", mem_rd_en, 0);
            chk("rst_mem_wr_en", mem_wr_en, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wr_data", mem_wr_data, 0);
            chk("rst_lock_active", lock_active, 0);
        end else begin
            exp_rv = '0;
            if (ret_owner.exists(cyc)) exp_rv[ret_owner[cyc]] = 1'b1;
            chk("m_rd_valid", rd_valid, exp_rv);
            if (ret_owner.exists(cyc)) chk("m_rd_data", rd_data, ret_data[cyc]);
            chk("m_mem_rd_en", mem_rd_en, m_rd);
            chk("m_mem_wr_en", mem_wr_en, m_wr);
            chk("m_mem_addr", mem_addr, m_addr);
            chk("m_mem_wr_data", mem_wr_data, m_wdata);
            chk("m_lock_active", lock_active, m_locked);

            exp_gnt = '0;
            g = -1;
            if (m_locked) begin
                if (req[m_owner]) g = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end
            if (g >= 0) exp_gnt[g] = 1'b1;
            chk("m_gnt", gnt, exp_gnt);

            if (g >= 0) begin
                m_addr  = req_addr[g*AW +: AW];
                m_wdata = req_wdata[g*DW +: DW];
                m_wr    = req_wr[g];
                m_rd    = !req_wr[g];
                if (req_wr[g]) begin
                    ref_mem[m_addr] = m_wdata;
                end else begin
                    ret_owner[cyc + 1 + RDL] = g;
                    ret_data[cyc + 1 + RDL]  = ref_mem.exists(m_addr) ? ref_mem[m_addr] : dflt(m_addr);
                end
                m_ptr = (g + 1) % N;
                if (m_locked) begin
                    if (!req_lock[g]) begin
                        m_locked = 0;
                    end else begin
                        m_cnt++;
                        if (m_cnt == ML) m_locked = 0;
                    end
                end else if (req_lock[g] && ML > 1) begin
                    m_locked = 1;
                    m_owner  = g;
                    m_cnt    = 1;
                end
            end else begin
                m_rd = 0;
                m_wr = 0;
                if (m_locked) begin
                    m_locked = 0;
                    m_ptr    = (m_owner + 1) % N;
                end
            end
        end
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic r, input logic w, input logic l,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]              = r;
        req_wr[i]           = w;
        req_lock[i]         = l;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic idle();
        req      = '0;
        req_wr   = '0;
        req_lock = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge hclk);
        #1;
        hresetn = 1'b1;

        // Single write then read of the same address
        set_req(0, 1, 1, 0, 32'h40, 32'hDEAD_BEEF);
        @(negedge hclk); chk("wr_gnt", gnt, 2'b01);
        tick();
        set_req(0, 1, 0, 0, 32'h40, 32'h0);
        @(negedge hclk);
        chk("wr_strobe", mem_wr_en, 1);
        chk("wr_addr", mem_addr, 32'h40);
        chk("wr_data", mem_wr_data, 32'hDEAD_BEEF);
        tick(); idle();
        @(negedge hclk);
        chk("rd_strobe", mem_rd_en, 1);
        chk("rd_wr_low", mem_wr_en, 0);
        tick();
        @(negedge hclk); chk("rd_not_early", rd_valid, 0);
        tick();
        @(negedge hclk);
        chk("rd_valid0", rd_valid, 2'b01);
        chk("rd_data0", rd_data, 32'hDEAD_BEEF);
        tick();

        // Round-robin: preload 0x200 via requester 1 so the pointer returns to 0
        set_req(1, 1, 1, 0, 32'h200, 32'h1234_5678);
        @(negedge hclk); chk("rr_pre_gnt", gnt, 2'b10);
        tick(); idle();
        set_req(0, 1, 0, 0, 32'h100, 32'h0);
        set_req(1, 1, 0, 0, 32'h200, 32'h0);
        for (int k = 0; k < 9; k++) begin
            @(negedge hclk);
            if (k < 6) chk($sformatf("rr_gnt%0d", k), gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k >= 3) begin
                chk($sformatf("rr_rv%0d", k), rd_valid, ((k - 3) % 2 == 0) ? 2'b01 : 2'b10);
                chk($sformatf("rr_rdata%0d", k), rd_data,
                    ((k - 3) % 2 == 0) ? 32'hA5A5_0100 : 32'h1234_5678);
            end
            tick();
            if (k == 5) idle();
        end

        // Lock: requester 1 holds four beats while requester 0 keeps requesting
        set_req(0, 1, 0, 0, 32'h300, 32'h0);
        @(negedge hclk); chk("lk_pre_gnt", gnt, 2'b01);
        tick();
        for (int k = 0; k < 4; k++) begin
            set_req(1, 1, 1, (k < 3), 32'h400 + 32'(4 * k), 32'hC0DE_0000 + 32'(k));
            @(negedge hclk);
            chk($sformatf("lk_gnt%0d", k), gnt, 2'b10);
            chk($sformatf("lk_active%0d", k), lock_active, (k > 0));
            tick();
        end
        set_req(1, 0, 0, 0, 32'h0, 32'h0);
        @(negedge hclk);
        chk("lk_rel_gnt", gnt, 2'b01);
        chk("lk_rel_active", lock_active, 0);
        tick(); idle();

        // Lock cap: requester 0 locks continuously, forced release after ML beats
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1, 1, 1, 32'h500 + 32'(4 * k), 32'hF00D_0000 + 32'(k));
            if (k > 0) set_req(1, 1, 0, 0, 32'h600, 32'h0);
            @(negedge hclk);
            chk($sformatf("cap_gnt%0d", k), gnt, 2'b01);
            chk($sformatf("cap_active%0d", k), lock_active, (k > 0));
            tick();
        end
        @(negedge hclk);
        chk("cap_rel_gnt", gnt, 2'b10);
        chk("cap_rel_active", lock_active, 0);
        tick(); idle();

        // Idle hold
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge hclk);
            chk($sformatf("idle_gnt%0d", k), gnt, 0);
            chk($sformatf("idle_addr%0d", k), mem_addr, 32'h600);
            chk($sformatf("idle_rd%0d", k), mem_rd_en, 0);
            chk($sformatf("idle_wr%0d", k), mem_wr_en, 0);
            tick();
        end

        // Reset in the middle of a read
        set_req(0, 1, 0, 0, 32'h40, 32'h0);
        @(negedge hclk); chk("mr_gnt", gnt, 2'b01);
        tick(); idle();
        chk("mr_rd_en_before", mem_rd_en, 1);
        hresetn = 1'b0;
        set_req(0, 1, 0, 0, 32'h40, 32'h0);
        set_req(1, 1, 0, 0, 32'h80, 32'h0);
        #1;
        chk("mr_rd_en", mem_rd_en, 0);
        chk("mr_wr_en", mem_wr_en, 0);
        chk("mr_addr", mem_addr, 0);
        chk("mr_wdata", mem_wr_data, 0);
        chk("mr_rv", rd_valid, 0);
        chk("mr_lock", lock_active, 0);
        chk("mr_gnt_rst", gnt, 0);
        tick();
        tick();
        hresetn = 1'b1;
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge hclk);
            chk($sformatf("mr_no_ret%0d", k), rd_valid, 0);
            tick();
        end
        set_req(0, 1, 0, 0, 32'h40, 32'h0);
        set_req(1, 1, 0, 0, 32'h80, 32'h0);
        @(negedge hclk); chk("mr_first_gnt", gnt, 2'b01);
        tick(); idle();
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares the single memory-side port (rd_en/wr_en/addr/wr_data/rd_data) between NUM_REQ requesters.
- Typical requesters: the AHB slave datapath plus a test/scrub/DMA agent.
- Accepts at most one access per cycle and drives registered memory strobes.
- Tracks in-flight reads so each read return is steered back to the requester that issued it.
- Supports locked sequences, capped at MAX_LOCK beats, so AHB bursts are not interleaved.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- RD_LATENCY, 1, cycles from a mem_rd_en-high cycle to valid mem_rd_data (1..4).
- MAX_LOCK, 16, maximum consecutive beats granted under lock before a forced release.

Ports:
- hclk  in  1  clock.
- hresetn  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester access request.
- req_wr  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  keep the grant for the next beat.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- gnt  out  NUM_REQ  combinational one-hot grant; the request is accepted on a rising edge where req[i]&&gnt[i].
- rd_valid  out  NUM_REQ  one-hot read-return strobe.
- rd_data  out  DATA_WIDTH  read return data; valid only with rd_valid.
- mem_rd_en  out  1  registered memory read strobe.
- mem_wr_en  out  1  registered memory write strobe.
- mem_addr  out  ADDR_WIDTH  registered memory address.
- mem_wr_data  out  DATA_WIDTH  registered memory write data.
- mem_rd_data  in  DATA_WIDTH  memory read data.
- lock_active  out  1  high while the arbiter is in state LOCKED.

Behaviour:
- Reset (asynchronous, hresetn low):
  - mem_rd_en, mem_wr_en, mem_addr, mem_wr_data = 0.
  - Read-tracking pipeline cleared, so rd_valid = 0.
  - RR pointer = 0, lock counter = 0, state = ARB, lock_active = 0.
  - Reads in flight at reset are discarded and never returned.
- States: ARB (normal round-robin) and LOCKED (grant pinned to owner).
- gnt in ARB:
  - One-hot to the first requester with req high, searching from the RR pointer upward with wrap-around.
  - gnt = 0 when no req is high.
- gnt in LOCKED: gnt[owner] = req[owner]; all other grant bits are 0.
- Acceptance at an edge (req[i]&&gnt[i]):
  - mem_addr and mem_wr_data are loaded from slice i.
  - Exactly one of mem_wr_en/mem_rd_en is set for one cycle, per req_wr[i].
  - RR pointer moves to (i+1) mod NUM_REQ.
- No acceptance: both strobes are 0 next cycle; mem_addr and mem_wr_data hold their values.
- Latency:
  - Memory strobe appears 1 cycle after the acceptance edge.
  - rd_valid[i] is high in the cycle RD_LATENCY cycles after the mem_rd_en cycle.
  - rd_data = mem_rd_data in that cycle (combinational pass-through).
- Read tracking:
  - Shift pipeline of depth RD_LATENCY carrying {valid, owner id}.
  - Back-to-back reads from different owners return in issue order, one per cycle.
- Lock transitions:
  - ARB -> LOCKED: on accepting a beat with req_lock[i]=1. owner = i, lock counter = 1.
  - Each further accepted beat with lock=1 increments the counter.
  - LOCKED -> ARB on any of:
    - an accepted beat with req_lock=0 (that beat is still accepted);
    - req[owner]=0 at an edge;
    - lock counter reaching MAX_LOCK, on the edge that accepts beat MAX_LOCK.
  - On exit, the RR pointer is owner+1 so another requester is served next.
- Writes and reads may issue on consecutive cycles; the memory is assumed to order them, so a write followed by a read of the same address returns the new data.
- Simultaneous return and acceptance are independent; throughput is 1 access per cycle.
- Fairness: in ARB with all requesters continuously requesting, each is granted once every NUM_REQ cycles.

Test Plan:
- Reset: hresetn low mid-read (RD_LATENCY=2) -> all outputs 0 immediately; after release, no rd_valid for the dropped read; first grant goes to requester 0.
- Single write/read: req0 writes 0xDEADBEEF to 0x40, then reads 0x40 -> mem_wr_en one cycle with addr 0x40; rd_valid[0]=1 with rd_data=0xDEADBEEF exactly RD_LATENCY cycles after mem_rd_en.
- Round-robin: req0 and req1 held high, 6 reads -> grant order 0,1,0,1,0,1; rd_valid pulses alternate 0,1 with no gaps.
- Lock: req1 with lock on 4 beats (last beat lock=0) while req0 is held high -> 4 consecutive grants to req1, lock_active high for the middle beats, then req0 granted.
- Lock cap: MAX_LOCK=4, req0 locks continuously while req1 is requesting -> req1 granted after 4 req0 beats; lock_active drops.
- Idle hold: no requests for 5 cycles -> strobes 0, mem_addr holds its last value, gnt=0.
